// File: rtl/skid_pipeline_register.sv
// rtl/skid_pipeline_register.sv - two-entry elastic pipeline register with registered handshake outputs
module skid_pipeline_register #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         accept, take;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = out_data;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && take) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A kill leaves stored data untouched; only occupancy is cleared.
    if (flush) begin
      state_d = EMPTY;
      main_d  = out_data;
      skid_d  = skid_q;
    end
  end

  // Handshake outputs are flops fed from next state, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      out_data  <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      state_q   <= state_d;
      out_data  <= main_d;
      skid_q    <= skid_d;
      out_valid <= (state_d != EMPTY);
      in_ready  <= (state_d != TWO);
      count     <= state_d;
    end
  end

endmodule

// File: doc/skid_pipeline_register.md
Name: skid_pipeline_register

Overview:
- Two-entry elastic pipeline register with a valid/ready handshake on both sides.
- It is the consumer-facing counterpart of the plain load-enabled register. The upstream stage writes when in_ready is high. The downstream stage reads and acknowledges through out_valid/out_ready.
- Used between datapath stages (e.g. decode to execute, or execute to a multi-cycle M-unit). It absorbs one cycle of downstream stall without a combinational path from out_ready to in_ready.

Parameters:
N, 32, data width in bits (N >= 1)

Ports:
clk        input   1    rising-edge clock
rst        input   1    asynchronous reset, active-low (0 = reset)
in_valid   input   1    upstream presents in_data
in_ready   output  1    block can accept this cycle; driven from a register, not from out_ready
in_data    input   N    upstream data
flush      input   1    synchronous discard of all held entries (branch/exception kill)
out_valid  output  1    out_data is valid
out_ready  input   1    downstream consumes this cycle
out_data   output  N    head entry
count      output  2    occupancy: 0, 1 or 2

Behaviour:
- Definitions: accept = in_valid & in_ready; take = out_valid & out_ready.
- Storage: main register (head, drives out_data) and skid register (second entry). State is EMPTY / ONE / TWO, encoded so that count = 0/1/2.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - state = EMPTY, out_valid = 0, in_ready = 1, count = 0.
  - out_data = 0 and skid register = 0.
  - After rst deasserts, the first accept is allowed on the first clock edge.
- Registered outputs: out_valid = (state != EMPTY), in_ready = (state != TWO), count from state. All outputs are purely registered.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main <= in_data. Otherwise stay.
  - ONE, accept & take -> ONE, main <= in_data.
  - ONE, accept & !take -> TWO, skid <= in_data, main unchanged.
  - ONE, !accept & take -> EMPTY.
  - ONE, neither -> stay.
  - TWO: in_ready = 0, so accept cannot occur. take -> ONE, main <= skid. Otherwise stay.
- Latency: data accepted at edge k is on out_data with out_valid = 1 after edge k, and is first takeable in cycle k+1. Through an empty buffer this is 1 cycle.
- Throughput: 1 transfer/cycle sustained while out_ready = 1.
- Ordering: strict FIFO. No entry is dropped, duplicated or reordered.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid hold unchanged.
- in_valid while in_ready = 0 is ignored. in_data is not sampled.
- Flush (sampled at the clock edge):
  - Next state = EMPTY, regardless of accept/take in the same cycle. A concurrent accept is discarded.
  - out_valid = 0 and in_ready = 1 from the next cycle.
  - main/skid contents are don't-care after flush. They need not be cleared.
- rst takes priority over flush. flush takes priority over all handshake activity.
- out_ready while out_valid = 0 has no effect.
- X-safety: in_data is never written into state while accept = 0.

Test Plan:
1. Reset hold:
   - Stimulus: rst = 0 for 3 cycles with in_valid = 1, in_data = 32'hDEADBEEF.
   - Required: out_valid = 0, in_ready = 1, count = 0, out_data = 0 throughout. After rst = 1, the first edge with in_valid accepts 32'hDEADBEEF.
2. Streaming:
   - Stimulus: out_ready = 1, in_valid = 1 with data 1, 2, 3 … 10 on consecutive cycles.
   - Required: out_data = 1 … 10 on consecutive cycles starting 1 cycle later. count stays 1, in_ready stays 1.
3. Skid absorb:
   - Stimulus: pushes A = 32'h11, B = 32'h22, C = 32'h33 back-to-back. out_ready = 0 from the cycle A becomes valid.
   - Required: A and B are accepted and C is refused. in_ready = 0, count = 2, out_data = 32'h11 held stable. C stays asserted upstream.
   - Then: raise out_ready. Required output order is 11, 22, 33 with no gaps after the first take.
4. Full + simultaneous:
   - Stimulus: state TWO (A, B), out_ready = 1 for one cycle, in_valid = 1 with C.
   - Required: A is taken and C is not accepted that cycle, because in_ready was 0. Next cycle: count = 1, out_data = B, in_ready = 1.
5. Flush:
   - Stimulus: state TWO, flush = 1 for one cycle with in_valid = 1 (D) and out_ready = 0.
   - Required: next cycle out_valid = 0, count = 0, in_ready = 1, and D is never seen on the output. A later push E appears as the next output.
6. Async reset mid-operation:
   - Stimulus: state TWO, rst dropped between clock edges.
   - Required: out_valid = 0, in_ready = 1, count = 0 immediately, without waiting for a clock edge. No stale data emerges after release.
